// File: rtl/uart_calc_rx.sv
// rtl/uart_calc_rx.sv - UART operand receiver with add/sub/mult/div of two OPERAND_BYTES operands
// Macro UART_CALC_PARITY_EN selects 8E1 frames with a parity check; otherwise frames are 8N1.
module uart_calc_rx #(
  parameter int CLKS_PER_BIT  = 2604,
  parameter int OPERAND_BYTES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         serial,
  input  logic                         addBut,
  input  logic                         subBut,
  input  logic                         multBut,
  input  logic                         divBut,
  output logic [8*OPERAND_BYTES-1:0]   result,
  output logic                         result_valid,
  output logic                         div_zero,
  output logic                         frame_err,
  output logic                         parity_err,
  output logic                         busy
);

  localparam int W  = 8 * OPERAND_BYTES;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(2 * OPERAND_BYTES);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] CNT_LAST  = BW'(2 * OPERAND_BYTES - 1);
  localparam logic [BW-1:0] A_LAST    = BW'(OPERAND_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_CALC_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MULT, OP_DIV} op_t;

  logic [1:0]    sync_q, sync_d;
  logic          rx_prev_q, rx_prev_d;
  state_t        state_q, state_d;
  logic [CW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    data_q, data_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
  logic          result_valid_q, result_valid_d;
  logic          div_zero_q, div_zero_d;
  logic          frame_err_q, frame_err_d;
  op_t           op_q, op_d;
  logic          rx, fall, byte_ok;
  logic [W-1:0]  a_shift, b_shift;
`ifdef UART_CALC_PARITY_EN
  logic          parity_err_q, parity_err_d;
`endif

  assign rx   = sync_q[1];
  assign fall = rx_prev_q & ~rx;

  always_comb begin
    sync_d         = {sync_q[0], serial};
    rx_prev_d      = rx;
    state_d        = state_q;
    tmr_d          = tmr_q + 1'b1;
    bit_idx_d      = bit_idx_q;
    data_d         = data_q;
    byte_cnt_d     = byte_cnt_q;
    a_d            = a_q;
    b_d            = b_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    div_zero_d     = div_zero_q;
    frame_err_d    = 1'b0;
    byte_ok        = 1'b0;
`ifdef UART_CALC_PARITY_EN
    parity_err_d   = 1'b0;
`endif

    if (addBut)       op_d = OP_ADD;
    else if (subBut)  op_d = OP_SUB;
    else if (multBut) op_d = OP_MULT;
    else if (divBut)  op_d = OP_DIV;
    else              op_d = op_q;

    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (fall) state_d = S_START;
      end
      S_START: begin
        if (tmr_q == HALF_LAST) begin
          tmr_d     = '0;
          bit_idx_d = '0;
          state_d   = rx ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tmr_q == BIT_LAST) begin
          tmr_d     = '0;
          data_d    = {rx, data_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
`ifdef UART_CALC_PARITY_EN
          if (bit_idx_q == 3'd7) state_d = S_PARITY;
`else
          if (bit_idx_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_CALC_PARITY_EN
      S_PARITY: begin
        if (tmr_q == BIT_LAST) begin
          tmr_d = '0;
          // A bad parity bit abandons the frame; the high stop bit then reads as idle.
          if (rx != ^data_q) begin
            parity_err_d = 1'b1;
            byte_cnt_d   = '0;
            state_d      = S_IDLE;
          end else begin
            state_d = S_STOP;
          end
        end
      end
`endif
      S_STOP: begin
        if (tmr_q == BIT_LAST) begin
          tmr_d   = '0;
          state_d = fall ? S_START : S_IDLE;
          if (rx) begin
            byte_ok = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            byte_cnt_d  = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    a_shift      = a_q << 8;
    a_shift[7:0] = data_q;
    b_shift      = b_q << 8;
    b_shift[7:0] = data_q;

    if (byte_ok) begin
      if (byte_cnt_q <= A_LAST) a_d = a_shift;
      else                      b_d = b_shift;
      if (byte_cnt_q == CNT_LAST) begin
        byte_cnt_d     = '0;
        result_valid_d = 1'b1;
        div_zero_d     = 1'b0;
        // op_d so that a button held on the stop-sample cycle still counts.
        case (op_d)
          OP_ADD:  result_d = a_q + b_shift;
          OP_SUB:  result_d = a_q - b_shift;
          OP_MULT: result_d = a_q * b_shift;
          default: begin
            if (b_shift == '0) begin
              result_d   = '1;
              div_zero_d = 1'b1;
            end else begin
              result_d = a_q / b_shift;
            end
          end
        endcase
      end else begin
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q         <= 2'b11;
      rx_prev_q      <= 1'b1;
      state_q        <= S_IDLE;
      tmr_q          <= '0;
      bit_idx_q      <= '0;
      data_q         <= '0;
      byte_cnt_q     <= '0;
      a_q            <= '0;
      b_q            <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      div_zero_q     <= 1'b0;
      frame_err_q    <= 1'b0;
      op_q           <= OP_ADD;
`ifdef UART_CALC_PARITY_EN
      parity_err_q   <= 1'b0;
`endif
    end else begin
      sync_q         <= sync_d;
      rx_prev_q      <= rx_prev_d;
      state_q        <= state_d;
      tmr_q          <= tmr_d;
      bit_idx_q      <= bit_idx_d;
      data_q         <= data_d;
      byte_cnt_q     <= byte_cnt_d;
      a_q            <= a_d;
      b_q            <= b_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      div_zero_q     <= div_zero_d;
      frame_err_q    <= frame_err_d;
      op_q           <= op_d;
`ifdef UART_CALC_PARITY_EN
      parity_err_q   <= parity_err_d;
`endif
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign div_zero     = div_zero_q;
  assign frame_err    = frame_err_q;
  assign busy         = (byte_cnt_q != '0) || (state_q != S_IDLE);
`ifdef UART_CALC_PARITY_EN
  assign parity_err   = parity_err_q;
`else
  assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_calc_rx.sv
// tb/tb_uart_calc_rx.sv - scoreboard bench for uart_calc_rx with a behavioural arithmetic model
module tb_uart_calc_rx;

  localparam int CPB = 16;
  localparam int OB  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        serial;
  logic        addBut, subBut, multBut, divBut;
  logic [15:0] result;
  logic        result_valid, div_zero, frame_err, parity_err, busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_res_q[$];
  logic        exp_dz_q[$];
  int          fe_cnt = 0, pe_cnt = 0, exp_fe = 0, exp_pe = 0;
  logic        prev_rv = 1'b0;
  int          op_m;

  uart_calc_rx #(.CLKS_PER_BIT(CPB), .OPERAND_BYTES(OB)) dut (
    .clk(clk), .rst(rst), .serial(serial),
    .addBut(addBut), .subBut(subBut), .multBut(multBut), .divBut(divBut),
    .result(result), .result_valid(result_valid), .div_zero(div_zero),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference arithmetic: op 0 add, 1 sub, 2 mult, 3 div; returns {div_zero, result}.
  function automatic logic [16:0] model(input int op, input int unsigned a, input int unsigned b);
    int unsigned r;
    case (op)
      0: r = (a + b) % 65536;
      1: r = (a + 65536 - b) % 65536;
      2: r = (a * b) % 65536;
      default: begin
        if (b == 0) return {1'b1, 16'hFFFF};
        r = a / b;
      end
    endcase
    return {1'b0, r[15:0]};
  endfunction

  initial begin : monitor
    logic [15:0] r;
    logic        d;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (result_valid) begin
          check("result_valid_single_cycle", {31'b0, prev_rv}, 32'd0);
          if (exp_res_q.size() == 0) begin
            check("unexpected_result_valid", {31'b0, result_valid}, 32'd0);
          end else begin
            r = exp_res_q.pop_front();
            d = exp_dz_q.pop_front();
            check("result", {16'b0, result}, {16'b0, r});
            check("div_zero", {31'b0, div_zero}, {31'b0, d});
          end
        end
        if (frame_err)  fe_cnt++;
        if (parity_err) pe_cnt++;
      end
      prev_rv = result_valid;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    serial = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_CALC_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop_b);
  endtask

`ifdef UART_CALC_PARITY_EN
  task automatic send_byte_par(input logic [7:0] d, input logic pbit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(pbit);
    send_bit(1'b1);
  endtask
`endif

  task automatic press(input int op);
    addBut  = (op == 0);
    subBut  = (op == 1);
    multBut = (op == 2);
    divBut  = (op == 3);
    repeat (2) @(negedge clk);
    addBut = 0; subBut = 0; multBut = 0; divBut = 0;
    op_m = op;
  endtask

  // op 4 keeps the currently latched operator.
  task automatic run_set(input int op, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    logic [16:0] m;
    if (op < 4) press(op);
    m = model(op_m, int'({b0, b1}), int'({b2, b3}));
    exp_res_q.push_back(m[15:0]);
    exp_dz_q.push_back(m[16]);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
  endtask

  initial begin
    rst = 1; serial = 1; addBut = 0; subBut = 0; multBut = 0; divBut = 0; op_m = 0;
    repeat (3) @(negedge clk);
    check("reset_result", {16'b0, result}, 32'd0);
    check("reset_result_valid", {31'b0, result_valid}, 32'd0);
    check("reset_div_zero", {31'b0, div_zero}, 32'd0);
    check("reset_frame_err", {31'b0, frame_err}, 32'd0);
    check("reset_parity_err", {31'b0, parity_err}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    rst = 0;
    repeat (5) @(negedge clk);

    run_set(0, 8'h00, 8'h07, 8'h00, 8'h03);
    run_set(1, 8'h00, 8'h03, 8'h00, 8'h07);
    run_set(2, 8'h01, 8'h00, 8'h01, 8'h00);
    run_set(3, 8'h00, 8'h64, 8'h00, 8'h00);
    run_set(4, 8'h00, 8'h64, 8'h00, 8'h07);

    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    exp_fe++;
    serial = 1;
    repeat (3 * CPB) @(negedge clk);
    check("busy_after_frame_err", {31'b0, busy}, 32'd0);
    check("frame_err_count", fe_cnt, exp_fe);
    run_set(4, 8'h00, 8'h50, 8'h00, 8'h04);

    serial = 0;
    repeat (3) @(negedge clk);
    serial = 1;
    repeat (2 * CPB) @(negedge clk);
    check("busy_after_glitch", {31'b0, busy}, 32'd0);
    check("frame_err_after_glitch", fe_cnt, exp_fe);
    check("no_pending_after_glitch", exp_res_q.size(), 32'd0);

    run_set(3, 8'h12, 8'h34, 8'h00, 8'h00);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    check("busy_mid_set", {31'b0, busy}, 32'd1);
    send_bit(1'b0);
    serial = 1;
    repeat (5) @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    check("midreset_result", {16'b0, result}, 32'd0);
    check("midreset_div_zero", {31'b0, div_zero}, 32'd0);
    check("midreset_busy", {31'b0, busy}, 32'd0);
    check("midreset_result_valid", {31'b0, result_valid}, 32'd0);
    rst = 0;
    op_m = 0;
    repeat (4) @(negedge clk);
    run_set(4, 8'h00, 8'h05, 8'h00, 8'h06);

`ifdef UART_CALC_PARITY_EN
    press(0);
    send_byte_par(8'h07, 1'b0);
    exp_pe++;
    repeat (CPB) @(negedge clk);
    check("parity_err_count", pe_cnt, exp_pe);
    check("busy_after_parity_err", {31'b0, busy}, 32'd0);
    run_set(4, 8'h07, 8'h00, 8'h00, 8'h01);
`endif

    for (int k = 0; k < 8; k++) begin
      int op;
      logic [7:0] r0, r1, r2, r3;
      op = $urandom_range(0, 4);
      r0 = 8'($urandom_range(0, 255));
      r1 = 8'($urandom_range(0, 255));
      r2 = 8'($urandom_range(0, 255));
      r3 = 8'($urandom_range(0, 255));
      if (op == 3 && $urandom_range(0, 2) == 0) begin
        r2 = 8'h00;
        r3 = 8'h00;
      end
      run_set(op, r0, r1, r2, r3);
    end

    for (int i = 0; i < 500 && exp_res_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", exp_res_q.size(), 32'd0);
    check("final_frame_err_count", fe_cnt, exp_fe);
    check("final_parity_err_count", pe_cnt, exp_pe);
    check("final_busy", {31'b0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_calc_rx.md
# uart_calc_rx

Parametrised UART operand receiver and arithmetic unit: deserialises 8N1 frames from `serial`, assembles two operands of `OPERAND_BYTES` bytes each, and applies the operation selected by the four operator buttons. It produces a registered result with a one-cycle valid strobe. It sits between the board UART pin and the result/seven-segment display logic, and generalises the fixed 32-bit receive-and-compute path to any operand width and baud divisor, adding framing, divide-by-zero and glitch handling.

## Interface
- `CLKS_PER_BIT`, 2604, clk cycles per UART bit (25 MHz / 9600 baud); minimum 8.
- `OPERAND_BYTES`, 4, bytes per operand; result width W = 8*OPERAND_BYTES.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `serial`  in  1  UART line, idle high, asynchronous to `clk`.
- `addBut`, `subBut`, `multBut`, `divBut`  in  1 each  operator buttons, level-sensitive.
- `result`  out  W  last computed result.
- `result_valid`  out  1  one-cycle strobe when `result` updates.
- `div_zero`  out  1  sticky flag: last operation was a divide by zero.
- `frame_err`  out  1  one-cycle strobe on a bad stop bit.
- `parity_err`  out  1  one-cycle strobe on a parity mismatch.
- `busy`  out  1  high while a frame or operand set is in progress (byte count ≠ 0 or RX FSM ≠ IDLE).

## Operation
- `serial` passes through a 2-flop synchroniser; both flops reset to 1.
- RX FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE→START on a synchronised falling edge.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. If low → DATA; if high → IDLE (glitch, no byte).
  - DATA: 8 samples, LSB first, one every CLKS_PER_BIT cycles → PARITY or STOP.
  - STOP: sample. If high, the byte is accepted; if low, pulse `frame_err` and discard the byte. Either way → IDLE.
- Assembler: byte counter 0..2*OPERAND_BYTES-1.
  - Bytes 0..OPERAND_BYTES-1 shift into A, MSB byte first; the remaining bytes shift into B, also MSB byte first.
  - Any frame or parity error resets the counter to 0 and discards the partial operands.
- Operator latch: updated every cycle that any button is high, with priority add > sub > mult > div. Reset value is add.
- On acceptance of the final byte, compute with the latched operator:
  - add: (A+B) mod 2^W.
  - sub: (A−B) mod 2^W.
  - mult: low W bits of A*B.
  - div: unsigned floor(A/B). If B=0, result = all ones and `div_zero`=1.
- `div_zero` is cleared by any non-div-by-zero computation.
- The counter wraps to 0 after the computation; the next byte starts a new operand set.
- Reset value of every output is 0. `rst` mid-frame aborts the frame and the counter; the FSM returns to IDLE.

## Timing
- Synchroniser latency: 2 cycles.
- Data bit k is sampled CLKS_PER_BIT*(k+1) cycles after the start-bit check, and the stop bit one bit period after the last data/parity sample.
- `result` and `result_valid` update on the cycle after the final stop-bit sample; `result_valid` is high for exactly 1 cycle.
- `frame_err` and `parity_err` assert the cycle after the failing sample, for 1 cycle.
- A button change during the final stop bit takes effect only if it is latched on or before the stop-sample cycle.
- A falling edge arriving in the same cycle as the stop sample is detected; back-to-back frames are supported with zero idle bits.

## Configuration
- Macro `UART_CALC_PARITY_EN`:
  - **Defined:** frames are 8E1. The PARITY state samples one even-parity bit after the data bits. On a mismatch, `parity_err` pulses, the byte is discarded and the counter resets.
  - **Undefined:** frames are 8N1, the PARITY state is absent, and `parity_err` is tied to 0.

## Test plan
All scenarios use CLKS_PER_BIT=16 and OPERAND_BYTES=2.
- `addBut` pulsed, send 0x00,0x07,0x00,0x03 → `result`=0x000A, one `result_valid` pulse, `div_zero`=0.
- `subBut`, send 0x00,0x03,0x00,0x07 → 0xFFFC. `multBut`, send 0x01,0x00,0x01,0x00 → 0x0000 (truncated).
- `divBut`, send 0x00,0x64,0x00,0x00 → 0xFFFF with `div_zero`=1. Then 0x00,0x64,0x00,0x07 → 0x000E with `div_zero`=0.
- Second byte sent with stop bit 0 → `frame_err` pulse, no `result_valid`, `busy` falls to 0. Four fresh good bytes then compute correctly.
- A 3-cycle low glitch on idle `serial` → no byte, no error, `busy` returns to 0. `rst` asserted during byte 3 → all outputs 0, and the next 4 bytes form a full set.
- With `UART_CALC_PARITY_EN` defined, send 0x07 with parity bit 0 → `parity_err` pulse; sending 0x07 with parity bit 1 is accepted.
